// File: rtl/ready_logic_pkg.sv
// rtl/ready_logic_pkg.sv - shared types and widths for the XT bus wait-state / READY generator
package ready_logic_pkg;

    typedef enum logic [1:0] {IDLE, COUNT, HOLD, DONE} ready_state_t;

    localparam int WAIT_COUNT_WIDTH = 3;
    localparam int TIMEOUT_WIDTH    = 7;

    function automatic logic state_ready(input ready_state_t s);
        return (s == IDLE) || (s == DONE);
    endfunction

endpackage

// File: rtl/ready_logic_cpu_clock_edge.sv
// rtl/ready_logic_cpu_clock_edge.sv - detects cpu_clock edges in the system clock domain
module cpu_clock_edge (
    input  logic clock,
    input  logic reset,
    input  logic cpu_clock,
    output logic cpu_posedge,
    output logic cpu_negedge
);

    logic prev_cpu_clock_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_cpu_clock_q <= 1'b0;
        end else begin
            prev_cpu_clock_q <= cpu_clock;
        end
    end

    assign cpu_posedge = ~prev_cpu_clock_q & cpu_clock;
    assign cpu_negedge = prev_cpu_clock_q & ~cpu_clock;

endmodule

// File: rtl/ready_logic.sv
// rtl/ready_logic.sv - XT bus wait-state and two-stage READY generator; READY_TIMEOUT_EN adds a HOLD timeout
module ready_logic
    import ready_logic_pkg::*;
#(
    parameter int unsigned IO_WAIT_STATES  = 1,
    parameter int unsigned MEM_WAIT_STATES = 0,
    parameter int unsigned DMA_WAIT_STATES = 1,
    parameter int unsigned TIMEOUT_CYCLES  = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic cpu_clock,
    input  logic io_channel_ready,
    input  logic address_enable_n,
    input  logic dma_wait_n,
    input  logic io_read_n,
    input  logic io_write_n,
    input  logic memory_read_n,
    input  logic memory_write_n,
    output logic processor_ready,
    output logic dma_ready,
    output logic bus_timeout
);

    logic cpu_posedge;
    logic cpu_negedge;

    cpu_clock_edge u_cpu_clock_edge (
        .clock       (clock),
        .reset       (reset),
        .cpu_clock   (cpu_clock),
        .cpu_posedge (cpu_posedge),
        .cpu_negedge (cpu_negedge)
    );

    logic                        cmd_active;
    logic                        cmd_active_q;
    logic                        start;
    logic [WAIT_COUNT_WIDTH-1:0] load_value;
    logic [WAIT_COUNT_WIDTH-1:0] wait_count_q, wait_count_d;
    ready_state_t                state_q, state_d;
    logic                        is_dma_q, is_dma_d;
    logic                        timeout_hit;
    logic                        cpu_rdy;
    logic                        cpu_rdy_d;
    logic                        dma_rdy_d;
    logic                        ready_ff1_q;
    logic                        processor_ready_q;
    logic                        dma_ready_q;

    assign cmd_active = ~(io_read_n & io_write_n & memory_read_n & memory_write_n);
    assign start      = cmd_active & ~cmd_active_q;

    always_comb begin
        load_value = WAIT_COUNT_WIDTH'(MEM_WAIT_STATES);
        if (address_enable_n) begin
            load_value = WAIT_COUNT_WIDTH'(DMA_WAIT_STATES);
        end else if (!io_read_n || !io_write_n) begin
            load_value = WAIT_COUNT_WIDTH'(IO_WAIT_STATES);
        end
    end

`ifdef READY_TIMEOUT_EN
    localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [TIMEOUT_WIDTH-1:0] timeout_q;
    logic                     bus_timeout_q;

    assign timeout_hit = (timeout_q == TIMEOUT_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timeout_q     <= '0;
            bus_timeout_q <= 1'b0;
        end else if (state_q != HOLD) begin
            timeout_q <= '0;
        end else if (cpu_posedge) begin
            timeout_q <= timeout_q + TIMEOUT_WIDTH'(1);
            if (timeout_hit && !io_channel_ready && cmd_active) begin
                bus_timeout_q <= 1'b1;
            end
        end
    end

    assign bus_timeout = bus_timeout_q;
`else
    assign timeout_hit = 1'b0;
    assign bus_timeout = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        wait_count_d = wait_count_q;
        is_dma_d     = is_dma_q;
        if (cpu_posedge && (wait_count_q != '0)) begin
            wait_count_d = wait_count_q - WAIT_COUNT_WIDTH'(1);
        end
        case (state_q)
            IDLE: begin
                if (start) begin
                    wait_count_d = load_value;
                    is_dma_d     = address_enable_n;
                    state_d      = (load_value != '0) ? COUNT : HOLD;
                end
            end
            COUNT: begin
                if (cpu_posedge && (wait_count_q == WAIT_COUNT_WIDTH'(1))) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (cpu_posedge && (io_channel_ready || timeout_hit)) begin
                    state_d = DONE;
                end
            end
            default: ;
        endcase
        if (!cmd_active) begin
            state_d = IDLE;
        end
    end

    // The first stages sample the next-state readiness so the cpu posedge that
    // reaches DONE is the one that releases ready.
    assign cpu_rdy   = (state_ready(state_q) | is_dma_q) & dma_wait_n;
    assign cpu_rdy_d = (state_ready(state_d) | is_dma_d) & dma_wait_n;
    assign dma_rdy_d = state_ready(state_d) | ~is_dma_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cmd_active_q      <= 1'b0;
            state_q           <= IDLE;
            wait_count_q      <= '0;
            is_dma_q          <= 1'b0;
            ready_ff1_q       <= 1'b1;
            processor_ready_q <= 1'b1;
            dma_ready_q       <= 1'b1;
        end else begin
            cmd_active_q <= cmd_active;
            state_q      <= state_d;
            wait_count_q <= wait_count_d;
            is_dma_q     <= is_dma_d;
            if (cpu_posedge) begin
                ready_ff1_q <= cpu_rdy_d;
                dma_ready_q <= dma_rdy_d;
            end
            if (cpu_negedge) begin
                processor_ready_q <= ready_ff1_q & cpu_rdy;
            end
        end
    end

    assign processor_ready = processor_ready_q;
    assign dma_ready       = dma_ready_q;

endmodule

// File: doc/ready_logic.md
# ready_logic

Wait-state and READY generator for the XT bus. It sits directly upstream of the bus arbiter and drives its `dma_ready` input. It also supplies the 8088 with a synchronized READY, in the manner of the 8284 two-stage RDY/READY path. Inputs are the arbiter's command strobes, `address_enable_n` and `dma_wait_n`, together with the I/O channel ready line. From these it inserts programmable wait states for CPU I/O, CPU memory and DMA cycles.

## Interface
- `IO_WAIT_STATES`, 1, wait states added to CPU I/O cycles (0–7)
- `MEM_WAIT_STATES`, 0, wait states added to CPU memory cycles (0–7)
- `DMA_WAIT_STATES`, 1, wait states added to DMA cycles (0–7)
- `TIMEOUT_CYCLES`, 64, cpu_clock periods before a forced ready (used only with the macro)
- `clock` input 1 — system clock; one clock domain. All flops run on `posedge clock`.
- `reset` input 1 — asynchronous, active-high
- `cpu_clock` input 1 — CPU clock, sampled as data and edge-detected on `clock`
- `io_channel_ready` input 1 — expansion bus ready; 1 = ready
- `address_enable_n` input 1 — 1 = DMA owns the bus
- `dma_wait_n` input 1 — 0 = CPU must wait during hold handover
- `io_read_n`, `io_write_n`, `memory_read_n`, `memory_write_n` input 1 each — command strobes from the arbiter
- `processor_ready` output 1 — synchronized READY to the CPU
- `dma_ready` output 1 — ready to the DMA controller
- `bus_timeout` output 1 — sticky timeout flag

## Operation
- Edge detect: `prev_cpu_clock` is registered on `clock`.
  - `cpu_posedge = ~prev & cpu_clock`; `cpu_negedge = prev & ~cpu_clock`.
- Command start: `cmd_active = ~(io_read_n & io_write_n & memory_read_n & memory_write_n)`.
  - `start` is the rising edge of `cmd_active`, registered on `clock`.
- Load value on `start`:
  - `address_enable_n`=1 → `DMA_WAIT_STATES`.
  - Otherwise an I/O strobe low → `IO_WAIT_STATES`.
  - Otherwise → `MEM_WAIT_STATES`.
  - The cycle type (`is_dma`) is latched at the same time.
- Counter: `wait_count[2:0]` decrements by 1 on each `cpu_posedge`, saturating at 0.
- FSM; all transitions except those into IDLE are taken on `cpu_posedge`:
  - IDLE → COUNT on `start` (taken on `clock`) when the load value is ≠0.
  - IDLE → HOLD on `start` when the load value is 0.
  - COUNT → HOLD when `wait_count` is 1.
  - HOLD → DONE when `io_channel_ready`=1.
  - Any state → IDLE when `cmd_active`=0, evaluated on every `clock`. This has priority over all other transitions.
- Raw ready: `rdy = (state==IDLE | state==DONE)`.
  - CPU path: `cpu_rdy = rdy | is_dma`, gated by `dma_wait_n`.
  - DMA path: `dma_rdy = rdy | ~is_dma`.
- Simultaneous `start` and `cmd_active`=0 cannot occur; `start` implies `cmd_active`=1.
- A new `start` while not IDLE is ignored; commands do not nest.
- Reset mid-cycle: FSM → IDLE, counter → 0, both ready outputs go to 1 immediately.

## Timing
- Reset values:
  - `processor_ready`=1, `dma_ready`=1, `bus_timeout`=0.
  - `ready_ff1`=1, state IDLE, `wait_count`=0.
- CPU path, two stages as in the 8284:
  - `ready_ff1 <= cpu_rdy` on `cpu_posedge`.
  - `processor_ready <= ready_ff1 & cpu_rdy` on `cpu_negedge`.
  - Deassertion therefore reaches the CPU at most one cpu_clock period after `start`.
  - Assertion reaches the CPU half a period after the posedge on which DONE is reached.
- DMA path: `dma_ready <= dma_rdy` on `cpu_posedge`; a single stage.
- Wait-state count: N wait states with `io_channel_ready` held high give exactly N cpu_clock periods of ready=0.
- Channel ready: a channel-ready low stretches the cycle by one period for each posedge on which it is sampled low.

## Configuration
- `READY_TIMEOUT_EN` defined:
  - A 7-bit counter runs on `cpu_posedge` while the FSM is in HOLD.
  - When it reaches `TIMEOUT_CYCLES`-1, the FSM is forced to DONE and `bus_timeout` is set.
  - `bus_timeout` clears only on reset.
- `READY_TIMEOUT_EN` undefined:
  - The counter is absent and `bus_timeout` is tied to 0.
  - HOLD waits indefinitely.

## Structure
- `ready_logic_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, COUNT, HOLD, DONE} ready_state_t`.
  - `localparam WAIT_COUNT_WIDTH = 3`.
  - `localparam TIMEOUT_WIDTH = 7`.
- One sub-module, `cpu_clock_edge`: takes `clock`, `reset`, `cpu_clock`; outputs `cpu_posedge` and `cpu_negedge`. It is reusable by the arbiter.

## Test plan
- CPU `io_read_n` low, defaults, `io_channel_ready`=1:
  - `processor_ready` low for exactly 1 cpu period; returns high before `io_read_n` rises.
- CPU `memory_read_n` low, `MEM_WAIT_STATES`=0: `processor_ready` never deasserts.
- CPU I/O write with `io_channel_ready` low for 3 posedges: `processor_ready` low for 1+3=4 periods.
- DMA cycle (`address_enable_n`=1, `memory_write_n` low):
  - `dma_ready` low for 1 period.
  - `processor_ready` unaffected apart from the `dma_wait_n` gating.
- Reset asserted mid-COUNT: FSM IDLE, `processor_ready`=1, `dma_ready`=1 within the same `clock` cycle.
- `READY_TIMEOUT_EN`, `TIMEOUT_CYCLES`=64, `io_channel_ready` held low:
  - Ready is forced after 64 periods and `bus_timeout`=1.
  - `bus_timeout` stays 1 after the command ends.
